clk_gate_ctrl: RTL and testbench



---
 rtl/clk_gate_pkg.sv | 27 ++
 rtl/clk_gate_ctrl.sv | 142 ++++++++++++++
 tb/tb_clk_gate_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/clk_gate_pkg.sv
// Shared types and defaults for the clk_d clock-gate enable controller.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'b00,
    IDLE   = 2'b01,
    GATED  = 2'b10,
    WAKE   = 2'b11
  } gate_state_e;

  localparam int DEF_IDLE_CYCLES = 4;
  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int GATE_CNT_W      = 16;

  // Saturating increment for the gating-event statistic.
  function automatic logic [GATE_CNT_W-1:0] sat_inc(input logic [GATE_CNT_W-1:0] val);
    logic [GATE_CNT_W-1:0] res;
    if (val == {GATE_CNT_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/clk_gate_ctrl.sv
// Enable controller for the clk_d gate: idle-run gating, activity/wake re-enable, wake_req/ack.
// Optional gating-event counter enabled by defining CLK_GATE_STATS_EN.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        busy,
  input  logic        force_on,
  input  logic        wake_req,
  output logic        en,
  output logic        gated,
  output logic        wake_ack,
  output logic [15:0] gate_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES);

  gate_state_e      state_r, state_next_s;
  logic [CNT_W-1:0] idle_cnt_r, idle_cnt_next_s;
  logic [CNT_W-1:0] wake_cnt_r, wake_cnt_next_s;
  logic             en_r, gated_r, wake_ack_r;
  logic             ack_next_s;
  logic             wake_acked_r, wake_acked_next_s;
  logic             quiet_s, new_req_s;

  // wake_acked_r marks that the current high phase of wake_req has been acknowledged.
  assign quiet_s   = ~busy & ~force_on & ~wake_req;
  assign new_req_s = wake_req & ~wake_acked_r;

  // Next-state, counter and acknowledge decode.
  always_comb begin
    state_next_s    = state_r;
    idle_cnt_next_s = idle_cnt_r;
    wake_cnt_next_s = wake_cnt_r;
    ack_next_s      = 1'b0;
    case (state_r)
      ACTIVE: begin
        if (quiet_s) begin
          state_next_s    = IDLE;
          idle_cnt_next_s = CNT_ONE;
        end else begin
          ack_next_s = new_req_s;
        end
      end
      IDLE: begin
        if (!quiet_s) begin
          state_next_s    = ACTIVE;
          idle_cnt_next_s = '0;
          ack_next_s      = new_req_s;
        end else if (idle_cnt_r == IDLE_LAST) begin
          state_next_s    = GATED;
          idle_cnt_next_s = '0;
        end else begin
          idle_cnt_next_s = idle_cnt_r + CNT_ONE;
        end
      end
      GATED: begin
        if (!quiet_s) begin
          state_next_s    = WAKE;
          wake_cnt_next_s = CNT_ONE;
        end else begin
          state_next_s = GATED;
        end
      end
      WAKE: begin
        // Activity inputs are ignored here; only the settle count matters.
        if (wake_cnt_r == WAKE_LAST) begin
          state_next_s    = ACTIVE;
          wake_cnt_next_s = '0;
          ack_next_s      = new_req_s;
        end else begin
          wake_cnt_next_s = wake_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s    = ACTIVE;
        idle_cnt_next_s = '0;
        wake_cnt_next_s = '0;
      end
    endcase

    if (!wake_req) begin
      wake_acked_next_s = 1'b0;
    end else if (ack_next_s) begin
      wake_acked_next_s = 1'b1;
    end else begin
      wake_acked_next_s = wake_acked_r;
    end
  end

  // State, counters and registered outputs; reset keeps the gated domain clocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ACTIVE;
      idle_cnt_r   <= '0;
      wake_cnt_r   <= '0;
      en_r         <= 1'b1;
      gated_r      <= 1'b0;
      wake_ack_r   <= 1'b0;
      wake_acked_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      idle_cnt_r   <= idle_cnt_next_s;
      wake_cnt_r   <= wake_cnt_next_s;
      en_r         <= (state_next_s != GATED);
      gated_r      <= (state_next_s == GATED);
      wake_ack_r   <= ack_next_s;
      wake_acked_r <= wake_acked_next_s;
    end
  end

  assign en       = en_r;
  assign gated    = gated_r;
  assign wake_ack = wake_ack_r;

`ifdef CLK_GATE_STATS_EN
  logic [GATE_CNT_W-1:0] gate_cnt_r;

  // Count entries into GATED, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt_r <= 16'h0;
    end else if ((state_r != GATED) && (state_next_s == GATED)) begin
      gate_cnt_r <= sat_inc(gate_cnt_r);
    end else begin
      gate_cnt_r <= gate_cnt_r;
    end
  end

  assign gate_cnt = gate_cnt_r;
`else
  assign gate_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed self-checking bench for clk_gate_ctrl (IDLE_CYCLES=4, WAKE_CYCLES=2, 10-unit clock).
module tb_clk_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic        force_on;
  logic        wake_req;
  logic        en;
  logic        gated;
  logic        wake_ack;
  logic [15:0] gate_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int exp_gc  = 0;

  clk_gate_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2),
    .CNT_W      (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (busy),
    .force_on(force_on),
    .wake_req(wake_req),
    .en      (en),
    .gated   (gated),
    .wake_ack(wake_ack),
    .gate_cnt(gate_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_gc(input string tag);
`ifdef CLK_GATE_STATS_EN
    check_val(tag, {16'h0, gate_cnt}, exp_gc);
`else
    check_val(tag, {16'h0, gate_cnt}, 32'h0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; busy = 1'b0; force_on = 1'b0; wake_req = 1'b0;
    steps(2);
    check_val("rst_en", en, 1'b1);
    check_val("rst_gated", gated, 1'b0);
    check_val("rst_ack", wake_ack, 1'b0);
    check_gc("rst_gcnt");

    // Release reset: gate on the 4th quiet edge.
    rst_n = 1'b1;
    steps(3);
    check_val("idle3_en", en, 1'b1);
    check_val("idle3_gated", gated, 1'b0);
    step();
    check_val("gate_en", en, 1'b0);
    check_val("gate_gated", gated, 1'b1);
    exp_gc = 1;
    check_gc("gcnt_1");

    // Wake from gated via wake_req: ack 2 edges after re-enable.
    wake_req = 1'b1;
    step();
    check_val("wk_en", en, 1'b1);
    check_val("wk_gated", gated, 1'b0);
    check_val("wk_ack_e1", wake_ack, 1'b0);
    step();
    check_val("wk_ack_e2", wake_ack, 1'b0);
    step();
    check_val("wk_ack_e3", wake_ack, 1'b1);
    step();
    check_val("wk_ack_once", wake_ack, 1'b0);
    steps(5);
    check_val("wk_hold_en", en, 1'b1);
    check_val("wk_hold_ack", wake_ack, 1'b0);
    wake_req = 1'b0;
    steps(3);
    check_val("wk_rel3_en", en, 1'b1);
    step();
    check_val("wk_rel4_en", en, 1'b0);
    exp_gc = 2;

    // Busy wakes (no ack), then wake_req while running acks next edge.
    busy = 1'b1;
    step();
    check_val("bw_en", en, 1'b1);
    steps(2);
    check_val("bw_ack", wake_ack, 1'b0);
    wake_req = 1'b1;
    step();
    check_val("run_ack", wake_ack, 1'b1);
    step();
    check_val("run_ack_once", wake_ack, 1'b0);
    busy = 1'b0;
    steps(5);
    check_val("run_hold_en", en, 1'b1);
    check_val("run_hold_ack", wake_ack, 1'b0);
    wake_req = 1'b0;
    steps(3);
    check_val("run_rel3_en", en, 1'b1);
    step();
    check_val("run_rel4_en", en, 1'b0);
    exp_gc = 3;
    check_gc("gcnt_3");

    // Idle abort on the final counting edge, then a fresh full count.
    busy = 1'b1;
    steps(3);
    busy = 1'b0;
    steps(3);
    check_val("ab_idle3_en", en, 1'b1);
    busy = 1'b1;
    step();
    check_val("ab_busy_en", en, 1'b1);
    check_val("ab_busy_gated", gated, 1'b0);
    busy = 1'b0;
    steps(3);
    check_val("ab_fresh3_en", en, 1'b1);
    step();
    check_val("ab_fresh4_en", en, 1'b0);
    exp_gc = 4;

    // force_on wakes and blocks gating while held.
    force_on = 1'b1;
    step();
    check_val("fo_en", en, 1'b1);
    steps(7);
    check_val("fo_hold_en", en, 1'b1);
    check_val("fo_hold_ack", wake_ack, 1'b0);
    force_on = 1'b0;
    steps(3);
    check_val("fo_rel3_en", en, 1'b1);
    step();
    check_val("fo_rel4_en", en, 1'b0);
    exp_gc = 5;

    // wake_req dropped during WAKE: no ack, WAKE still completes.
    wake_req = 1'b1;
    step();
    check_val("drop_en", en, 1'b1);
    wake_req = 1'b0;
    step();
    check_val("drop_ack_e2", wake_ack, 1'b0);
    step();
    check_val("drop_ack_e3", wake_ack, 1'b0);
    step();
    check_val("drop_ack_e4", wake_ack, 1'b0);
    steps(2);
    check_val("drop_idle_en", en, 1'b1);
    step();
    check_val("drop_gate_en", en, 1'b0);
    exp_gc = 6;
    check_gc("gcnt_6");

    // Async reset while gated: en rises without a clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_g_en", en, 1'b1);
    check_val("arst_g_gated", gated, 1'b0);
    exp_gc = 0;
    check_gc("arst_gcnt");
    step();
    rst_n = 1'b1;
    steps(3);
    check_val("arst_g_idle_en", en, 1'b1);
    step();
    check_val("arst_g_gate_en", en, 0);
    exp_gc = 1;

    // Async reset mid-WAKE, no ack after release.
    wake_req = 1'b1;
    step();
    step();
    #3;
    rst_n = 1'b0;
    wake_req = 1'b0;
    #1;
    check_val("arst_w_en", en, 1'b1);
    check_val("arst_w_ack", wake_ack, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check_val("post_ack_1", wake_ack, 1'b0);
    step();
    check_val("post_ack_2", wake_ack, 1'b0);
    step();
    check_val("post_ack_3", wake_ack, 1'b0);
    step();
    check_val("post_gate_en", en, 1'b0);
    exp_gc = 1;
    check_gc("post_gcnt");

`ifdef CLK_GATE_STATS_EN
    // Preload near saturation; two further gatings must stop at 16'hFFFF.
    force dut.gate_cnt_r = 16'hFFFE;
    #1;
    release dut.gate_cnt_r;
    exp_gc = 32'hFFFE;
    check_gc("sat_preload");
    for (int k = 0; k < 2; k++) begin
      busy = 1'b1;
      steps(3);
      busy = 1'b0;
      steps(4);
      check_val("sat_gate_en", en, 1'b0);
      exp_gc = 32'hFFFF;
      check_gc("sat_gcnt");
    end
`else
    check_gc("nostats_gcnt");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
